// File: rtl/score_digits_display_if.sv
// Pixel/score bus between the pong overlay timing logic and the score digit renderer.
interface score_digits_display_if #(
    parameter int SCORE_W = 7
) ();
    logic               frame_start;
    logic [SCORE_W-1:0] score;
    logic [10:0]        x;
    logic [10:0]        y;
    logic [11:0]        rgb;
    logic               busy;

    modport master (output frame_start, score, x, y, input rgb, busy);
    modport slave  (input frame_start, score, x, y, output rgb, busy);
endinterface

// File: rtl/score_digits_display.sv
// Multi-digit seven-segment score overlay: per-frame latch, sequential double-dabble, 2-stage pixel path.
// Optional blink after a score change is enabled by defining SCORE_BLINK_EN.
module score_digits_display #(
    parameter int          XLOC         = 100,
    parameter int          YLOC         = 100,
    parameter int          DIGITS       = 2,
    parameter int          SEG_LEN      = 20,
    parameter int          SEG_W        = 4,
    parameter int          DIGIT_GAP    = 10,
    parameter int          SCORE_W      = 7,
    parameter logic [11:0] COLOR        = 12'hFFF,
    parameter int          BLINK_FRAMES = 60
) (
    input logic                   clk,
    input logic                   rst_n,
    score_digits_display_if.slave bus
);
    localparam int BW   = 4 * DIGITS;
    localparam int CW   = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam int MAXV = 10 ** DIGITS - 1;

    localparam logic [10:0] L_SW   = 11'(SEG_W);
    localparam logic [10:0] L_SL   = 11'(SEG_LEN);
    localparam logic [10:0] L_DW   = 11'(2 * SEG_W + SEG_LEN);
    localparam logic [10:0] L_DH   = 11'(3 * SEG_W + 2 * SEG_LEN);
    localparam logic [10:0] L_YLOC = 11'(YLOC);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [SCORE_W-1:0] shadow_q, score_sat;
    logic [BW-1:0]      bcd_q, bcd_adj, digits_q;
    logic               load, shift, commit;
    logic               blank;

    assign score_sat = (32'(bus.score) > 32'(MAXV)) ? SCORE_W'(MAXV) : bus.score;

    // A new frame_start always wins, even mid-conversion: the stale result is dropped.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE:   ;
            S_CONV: begin
                shift = 1'b1;
                if (cnt_q == '0) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
        if (bus.frame_start) begin
            load    = 1'b1;
            shift   = 1'b0;
            state_d = S_CONV;
        end
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_adj[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_adj[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            bcd_q    <= '0;
            digits_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                shadow_q <= score_sat;
                bcd_q    <= '0;
                cnt_q    <= CW'(SCORE_W - 1);
            end else if (shift) begin
                shadow_q <= shadow_q << 1;
                bcd_q    <= {bcd_adj[BW-2:0], shadow_q[SCORE_W-1]};
                cnt_q    <= cnt_q - 1'b1;
            end
            if (commit) digits_q <= bcd_q;
        end
    end

    assign bus.busy = (state_q == S_CONV);

`ifdef SCORE_BLINK_EN
    localparam int BKW = ($clog2(BLINK_FRAMES + 1) < 4) ? 4 : $clog2(BLINK_FRAMES + 1);
    logic [BKW-1:0] blink_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= '0;
        end else if (commit && (bcd_q != digits_q)) begin
            blink_q <= BKW'(BLINK_FRAMES);
        end else if (bus.frame_start && (blink_q != '0)) begin
            blink_q <= blink_q - 1'b1;
        end
    end

    assign blank = (blink_q != '0) && blink_q[3];
`else
    assign blank = 1'b0;
`endif

    // Stage 1: locate the digit box under (x,y) and which segment areas it covers.
    logic [10:0] rx, ry, org;
    logic        in_y, hit, hx, lv, rv, up, lo;
    logic [1:0]  idx_d, idx_q;
    logic [6:0]  seg_d, seg_q;

    always_comb begin
        ry    = bus.y - L_YLOC;
        in_y  = (bus.y >= L_YLOC) && (ry < L_DH);
        rx    = '0;
        hit   = 1'b0;
        idx_d = '0;
        org   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            org = 11'(XLOC + i * (2 * SEG_W + SEG_LEN + DIGIT_GAP));
            if (in_y && (bus.x >= org) && ((bus.x - org) < L_DW)) begin
                hit   = 1'b1;
                idx_d = 2'(i);
                rx    = bus.x - org;
            end
        end
        hx = (rx >= L_SW) && (rx < L_SW + L_SL);
        lv = (rx < L_SW);
        rv = (rx >= L_SW + L_SL) && (rx < L_DW);
        up = (ry >= L_SW) && (ry < L_SW + L_SL);
        lo = (ry >= 2 * L_SW + L_SL) && (ry < 2 * L_SW + 2 * L_SL);
        seg_d = '0;
        if (hit) begin
            seg_d[0] = hx && (ry < L_SW);
            seg_d[1] = rv && up;
            seg_d[2] = rv && lo;
            seg_d[3] = hx && (ry >= 2 * L_SW + 2 * L_SL);
            seg_d[4] = lv && lo;
            seg_d[5] = lv && up;
            seg_d[6] = hx && (ry >= L_SW + L_SL) && (ry < 2 * L_SW + L_SL);
        end
    end

    // Stage 2: digit 0 is the most significant nibble; segment bit order is g..a.
    logic [3:0]  cur;
    logic [6:0]  mask;
    logic [11:0] rgb_q;

    always_comb begin
        cur = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == 2'(i)) cur = digits_q[4*(DIGITS-1-i) +: 4];
        end
        case (cur)
            4'd0:    mask = 7'h3F;
            4'd1:    mask = 7'h06;
            4'd2:    mask = 7'h5B;
            4'd3:    mask = 7'h4F;
            4'd4:    mask = 7'h66;
            4'd5:    mask = 7'h6D;
            4'd6:    mask = 7'h7D;
            4'd7:    mask = 7'h07;
            4'd8:    mask = 7'h7F;
            4'd9:    mask = 7'h6F;
            default: mask = 7'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            seg_q <= '0;
            rgb_q <= '0;
        end else begin
            idx_q <= idx_d;
            seg_q <= seg_d;
            rgb_q <= ((|(seg_q & mask)) && !blank) ? COLOR : 12'h000;
        end
    end

    assign bus.rgb = rgb_q;
endmodule

// File: tb/tb_score_digits_display.sv
// Randomized bench for score_digits_display against a geometry/arithmetic reference model.
module tb_score_digits_display;
    localparam int XLOC = 100, YLOC = 100, DIGITS = 2, SEG_LEN = 20, SEG_W = 4;
    localparam int DIGIT_GAP = 10, SCORE_W = 7, BLINK_FRAMES = 60;
    localparam logic [11:0] COLOR = 12'hFFF;
    localparam int DW = 2 * SEG_W + SEG_LEN, DH = 3 * SEG_W + 2 * SEG_LEN;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    score_digits_display_if #(.SCORE_W(SCORE_W)) bus ();

    score_digits_display #(
        .XLOC(XLOC), .YLOC(YLOC), .DIGITS(DIGITS), .SEG_LEN(SEG_LEN), .SEG_W(SEG_W),
        .DIGIT_GAP(DIGIT_GAP), .SCORE_W(SCORE_W), .COLOR(COLOR), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int m_val = 0;
    int m_blink = 0;
    string pat[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                       "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit seg_in(input int dg, input byte ch);
        string p;
        p = pat[dg];
        for (int k = 0; k < p.len(); k++) if (p[k] == ch) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [11:0] model_rgb(input int val, input int px, input int py);
        int ox, rx, ry, dg;
        bit lit;
        lit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            ox = XLOC + i * (DW + DIGIT_GAP);
            if (px >= ox && px < ox + DW && py >= YLOC && py < YLOC + DH) begin
                rx = px - ox;
                ry = py - YLOC;
                dg = (val / (10 ** (DIGITS - 1 - i))) % 10;
                if (rx >= SEG_W && rx < SEG_W + SEG_LEN) begin
                    if (ry < SEG_W) lit |= seg_in(dg, "a");
                    if (ry >= SEG_W + SEG_LEN && ry < 2 * SEG_W + SEG_LEN) lit |= seg_in(dg, "g");
                    if (ry >= 2 * SEG_W + 2 * SEG_LEN) lit |= seg_in(dg, "d");
                end
                if (ry >= SEG_W && ry < SEG_W + SEG_LEN) begin
                    if (rx < SEG_W) lit |= seg_in(dg, "f");
                    if (rx >= SEG_W + SEG_LEN) lit |= seg_in(dg, "b");
                end
                if (ry >= 2 * SEG_W + SEG_LEN && ry < 2 * SEG_W + 2 * SEG_LEN) begin
                    if (rx < SEG_W) lit |= seg_in(dg, "e");
                    if (rx >= SEG_W + SEG_LEN) lit |= seg_in(dg, "c");
                end
            end
        end
`ifdef SCORE_BLINK_EN
        if (m_blink != 0 && (m_blink & 8) != 0) lit = 1'b0;
`endif
        return lit ? COLOR : 12'h000;
    endfunction

    task automatic pulse_fs(input int s);
        @(posedge clk);
        #1 bus.frame_start = 1'b1;
        bus.score = SCORE_W'(s);
        @(posedge clk);
        #1 bus.frame_start = 1'b0;
        if (m_blink != 0) m_blink--;
    endtask

    task automatic run_frame(input int s);
        int n, sv;
        pulse_fs(s);
        n = 0;
        while (bus.busy && n < 50) begin
            n++;
            @(posedge clk);
            #1;
        end
        check_val("busy_len", n, SCORE_W);
        sv = (s > 10 ** DIGITS - 1) ? 10 ** DIGITS - 1 : s;
        if (sv != m_val) m_blink = BLINK_FRAMES;
        m_val = sv;
        @(posedge clk);
        #1;
    endtask

    task automatic check_pix(input string tag, input int px, input int py);
        @(posedge clk);
        #1 bus.x = 11'(px);
        bus.y = 11'(py);
        repeat (2) @(posedge clk);
        #1 check_val(tag, bus.rgb, model_rgb(m_val, px, py));
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.score = '0;
        bus.x = '0;
        bus.y = '0;
        repeat (3) @(posedge clk);
        #1 check_val("rst_rgb", bus.rgb, 0);
        check_val("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        check_pix("rst_zero_a", 110, 101);

        run_frame(7);
        check_pix("s7_d1_a", 144, 101);
        check_pix("s7_d1_g", 144, 125);
        check_pix("s7_d0_g", 110, 125);

        run_frame(127);
        check_pix("sat_gap", 130, 101);
        check_pix("sat_d1_c", 163, 140);
        check_pix("sat_d1_lower", 161, 140);
        check_pix("sat_d0_e", 101, 140);

        run_frame(88);
        @(posedge clk);
        #1 bus.x = 11'd99;
        bus.y = 11'd101;
        repeat (2) @(posedge clk);
        #1 bus.x = 11'd104;
        @(posedge clk);
        #1 check_val("lat_n1", bus.rgb, model_rgb(m_val, 99, 101));
        @(posedge clk);
        #1 check_val("lat_n2", bus.rgb, model_rgb(m_val, 104, 101));

        pulse_fs(5);
        repeat (2) @(posedge clk);
        run_frame(42);
        check_pix("b2b_d1_e", 139, 140);
        check_pix("b2b_d1_f", 139, 110);
        check_pix("b2b_d0_f", 101, 110);

        pulse_fs(33);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_val("midconv_busy", bus.busy, 0);
        check_val("midconv_rgb", bus.rgb, 0);
        m_val = 0;
        m_blink = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_pix("postrst_a", 110, 101);
        check_pix("postrst_g", 110, 125);

        for (int it = 0; it < 20; it++) begin
            run_frame(int'($urandom_range(0, 127)));
            for (int p = 0; p < 6; p++)
                check_pix("rand_pix", int'($urandom_range(97, 180)), int'($urandom_range(97, 172)));
        end

`ifdef SCORE_BLINK_EN
        run_frame(3);
        for (int f = 0; f < 70 && m_blink != 0; f++) run_frame(3);
        run_frame(4);
        for (int f = 0; f < 64; f++) begin
            check_pix("blink_b", 163, 110);
            run_frame(4);
        end
        check_pix("blink_steady", 163, 110);
        run_frame(4);
        check_pix("blink_same", 163, 110);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
